// File: rtl/vga_fb_writer.sv
// vga_fb_writer: owns the frame RAM write port, arbitrating pixel writes against a full-frame clear.
module vga_fb_writer #(
  parameter int H_RES        = 800,
  parameter int V_RES        = 480,
  parameter int FRAME_PIXELS = 384000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_start,
  input  logic [2:0]  clear_colour,
  input  logic        px_valid,
  input  logic [10:0] px_x,
  input  logic [10:0] px_y,
  input  logic [2:0]  px_colour,
  output logic        px_ready,
  output logic        px_err,
  output logic        busy,
  output logic        clear_done,
  output logic        ram_we,
  output logic [18:0] ram_waddr,
  output logic [2:0]  ram_d
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, next_state;
  logic [18:0] counter, waddr_n, addr, y19;
  logic [2:0] colour, d_n;
  logic we_n, err_n, done_n, accept, in_range, wr_px, last;
  assign px_ready = state == IDLE && !clear_start;
  assign accept   = px_valid && px_ready;
  assign in_range = px_x < 11'(H_RES) && px_y < 11'(V_RES);
  assign wr_px    = accept && in_range;
  assign y19      = {8'd0, px_y};
  // y*800 as y*512 + y*256 + y*32
  assign addr     = (y19 << 9) + (y19 << 8) + (y19 << 5) + {8'd0, px_x};
  // counter mirrors the address currently on ram_waddr during a clear
  assign last     = counter == 19'(FRAME_PIXELS - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  always_comb
    next_state = state == IDLE ? (clear_start ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
  always_comb begin
    we_n    = state == CLEAR ? !last : clear_start || wr_px;
    waddr_n = state == CLEAR ? (last ? ram_waddr : counter + 19'd1)
            : clear_start ? 19'd0 : wr_px ? addr : ram_waddr;
    d_n     = state == CLEAR ? colour : clear_start ? clear_colour : wr_px ? px_colour : ram_d;
    err_n   = accept && !in_range;
    done_n  = state == CLEAR && last;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ram_we     <= 1'b0;
      ram_waddr  <= '0;
      ram_d      <= '0;
      px_err     <= 1'b0;
      clear_done <= 1'b0;
      busy       <= 1'b0;
      counter    <= '0;
      colour     <= '0;
    end else begin
      ram_we     <= we_n;
      ram_waddr  <= waddr_n;
      ram_d      <= d_n;
      px_err     <= err_n;
      clear_done <= done_n;
      busy       <= next_state == CLEAR;
      counter    <= state == CLEAR && !last ? counter + 19'd1 : '0;
      colour     <= state == IDLE && clear_start ? clear_colour : colour;
    end
endmodule
